// File: rtl/bmu_search.sv
// Best-matching-unit search: streams one distance per node and tracks the minimum.
// Define SECOND_BMU_EN to also track the second-nearest node (sbmu_idx / sbmu_dist).
module bmu_search #(
  parameter int unsigned NUM_NODES = 16,
  parameter int unsigned DIST_W    = 32,
  parameter int unsigned IDX_W     = $clog2(NUM_NODES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIST_W-1:0] grow_thresh,
  input  logic              ed_valid,
  input  logic [DIST_W-1:0] ed_in,
  output logic [IDX_W-1:0]  node_addr,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  bmu_idx,
  output logic [DIST_W-1:0] bmu_dist,
`ifdef SECOND_BMU_EN
  output logic [IDX_W-1:0]  sbmu_idx,
  output logic [DIST_W-1:0] sbmu_dist,
`endif
  output logic              grow_req
);

  localparam logic [DIST_W-1:0] DIST_MAX = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_node_addr, w_node_addr_nxt;
  logic               r_busy, r_done;
  logic [IDX_W-1:0]   r_bmu_idx, w_bmu_idx_nxt;
  logic [DIST_W-1:0]  r_bmu_dist, w_bmu_dist_nxt;
  logic               r_grow_req, w_grow_req_nxt;
  logic [DIST_W-1:0]  r_thresh, w_thresh_nxt;
`ifdef SECOND_BMU_EN
  logic [IDX_W-1:0]   r_sbmu_idx, w_sbmu_idx_nxt;
  logic [DIST_W-1:0]  r_sbmu_dist, w_sbmu_dist_nxt;
`endif

  // Next-state and datapath update; every register holds unless a branch overrides it.
  always_comb begin
    w_state_nxt     = r_state;
    w_node_addr_nxt = r_node_addr;
    w_bmu_idx_nxt   = r_bmu_idx;
    w_bmu_dist_nxt  = r_bmu_dist;
    w_grow_req_nxt  = r_grow_req;
    w_thresh_nxt    = r_thresh;
`ifdef SECOND_BMU_EN
    w_sbmu_idx_nxt  = r_sbmu_idx;
    w_sbmu_dist_nxt = r_sbmu_dist;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt     = S_SCAN;
          w_node_addr_nxt = '0;
          w_bmu_idx_nxt   = '0;
          w_bmu_dist_nxt  = DIST_MAX;
          w_grow_req_nxt  = 1'b0;
          w_thresh_nxt    = grow_thresh;
`ifdef SECOND_BMU_EN
          w_sbmu_idx_nxt  = '0;
          w_sbmu_dist_nxt = DIST_MAX;
`endif
        end
      end
      S_SCAN: begin
        if (ed_valid) begin
          // Strict compares keep the lower index on ties.
          if (ed_in < r_bmu_dist) begin
`ifdef SECOND_BMU_EN
            w_sbmu_idx_nxt  = r_bmu_idx;
            w_sbmu_dist_nxt = r_bmu_dist;
`endif
            w_bmu_idx_nxt   = r_node_addr;
            w_bmu_dist_nxt  = ed_in;
          end
`ifdef SECOND_BMU_EN
          else if (ed_in < r_sbmu_dist) begin
            w_sbmu_idx_nxt  = r_node_addr;
            w_sbmu_dist_nxt = ed_in;
          end
`endif
          if (r_node_addr == LAST_IDX) begin
            w_state_nxt     = S_DONE;
            w_node_addr_nxt = '0;
            w_grow_req_nxt  = (w_bmu_dist_nxt > r_thresh);
          end else begin
            w_node_addr_nxt = r_node_addr + IDX_W'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and result registers; busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_node_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bmu_idx   <= '0;
      r_bmu_dist  <= DIST_MAX;
      r_grow_req  <= 1'b0;
      r_thresh    <= '0;
`ifdef SECOND_BMU_EN
      r_sbmu_idx  <= '0;
      r_sbmu_dist <= DIST_MAX;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_node_addr <= w_node_addr_nxt;
      r_busy      <= (w_state_nxt == S_SCAN);
      r_done      <= (w_state_nxt == S_DONE);
      r_bmu_idx   <= w_bmu_idx_nxt;
      r_bmu_dist  <= w_bmu_dist_nxt;
      r_grow_req  <= w_grow_req_nxt;
      r_thresh    <= w_thresh_nxt;
`ifdef SECOND_BMU_EN
      r_sbmu_idx  <= w_sbmu_idx_nxt;
      r_sbmu_dist <= w_sbmu_dist_nxt;
`endif
    end
  end

  assign node_addr = r_node_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bmu_idx   = r_bmu_idx;
  assign bmu_dist  = r_bmu_dist;
  assign grow_req  = r_grow_req;
`ifdef SECOND_BMU_EN
  assign sbmu_idx  = r_sbmu_idx;
  assign sbmu_dist = r_sbmu_dist;
`endif

endmodule
